// File: rtl/com_to_fifo_pkg.sv
// Shared definitions for the UART-receive-to-FIFO stage: FSM states, CRC polynomial, error bit map.
// No logic; latency n/a.
// Backpressure n/a.
package com_to_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        PUSH   = 3'd5
    } rxState_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam int ERR_FRAME    = 0;
    localparam int ERR_PARITY   = 1;
    localparam int ERR_OVERFLOW = 2;
    localparam int ERR_OVERRUN  = 3;

endpackage

// File: rtl/com_to_fifo_crc8_update.sv
// CRC-8 (MSB-first, no reflection) next value from current CRC and one byte.
// Latency: combinational.
// Backpressure: none.
module crc8_update
    import com_to_fifo_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ CRC8_POLY) : {crc_out[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/com_to_fifo.sv
// UART receiver feeding the shared FIFO, with running CRC-8 and sticky errors; COM_RX_PARITY_EN adds even parity.
// Latency: fifo_we in the cycle after the stop-bit sample (2-flop rx synchroniser ahead of start detection).
// Backpressure: holds the byte while fifo_busy; drops it and flags overflow if fifo_full.
module com_to_fifo
    import com_to_fifo_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx,
    input  logic       fifo_busy,
    input  logic       fifo_full,
    output logic       fifo_we,
    output logic [7:0] data_out,
    output logic [7:0] CRC,
    output logic [3:0] error,
    output logic       isFinish
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rxState_t             state, stateNxt;
    logic                 rxMeta, rxs, rxsPrev;
    logic [TICK_W-1:0]    tick, tickNxt;
    logic [BIT_W-1:0]     bitCnt, bitCntNxt;
    logic [DATA_BITS-1:0] shiftReg, shiftNxt;
    logic                 parErr, parErrNxt;
    logic [3:0]           errReg, errNxt;
    logic [7:0]           heldByte, crcReg, crcNxt, byteVal;
    logic                 rxFall;

    assign rxFall  = rxsPrev & ~rxs;
    assign byteVal = 8'(shiftReg);

    crc8_update u_crc (
        .crc_in  (crcReg),
        .data    (byteVal),
        .crc_out (crcNxt)
    );

    always_comb begin
        stateNxt  = state;
        tickNxt   = tick + 1'b1;
        bitCntNxt = bitCnt;
        shiftNxt  = shiftReg;
        parErrNxt = parErr;
        errNxt    = errReg;
        fifo_we   = 1'b0;
        isFinish  = 1'b0;
        case (state)
            IDLE: begin
                tickNxt   = '0;
                bitCntNxt = '0;
                parErrNxt = 1'b0;
                if (enable && rxFall) stateNxt = START;
            end
            START: begin
                if (tick == TICK_HALF) begin
                    tickNxt  = '0;
                    stateNxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == TICK_LAST) begin
                    tickNxt   = '0;
                    shiftNxt  = {rxs, shiftReg[DATA_BITS-1:1]};
                    bitCntNxt = bitCnt + 1'b1;
                    if (bitCnt == BIT_LAST) begin
`ifdef COM_RX_PARITY_EN
                        stateNxt = PARITY;
`else
                        stateNxt = STOP;
`endif
                    end
                end
            end
`ifdef COM_RX_PARITY_EN
            PARITY: begin
                if (tick == TICK_LAST) begin
                    tickNxt   = '0;
                    parErrNxt = (^shiftReg) ^ rxs;
                    stateNxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (tick == TICK_LAST) begin
                    tickNxt = '0;
                    if (rxs && !parErr) begin
                        stateNxt = PUSH;
                    end else begin
                        if (!rxs)  errNxt[ERR_FRAME]  = 1'b1;
                        if (parErr) errNxt[ERR_PARITY] = 1'b1;
                        stateNxt = IDLE;
                    end
                end
            end
            PUSH: begin
                tickNxt = '0;
                // A new start bit arriving while we still hold a byte cannot be tracked.
                if (rxFall) errNxt[ERR_OVERRUN] = 1'b1;
                if (!fifo_busy) begin
                    if (fifo_full) begin
                        errNxt[ERR_OVERFLOW] = 1'b1;
                    end else begin
                        fifo_we  = !reset;
                        isFinish = !reset;
                    end
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta   <= 1'b1;
            rxs      <= 1'b1;
            rxsPrev  <= 1'b1;
            state    <= IDLE;
            tick     <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            parErr   <= 1'b0;
            errReg   <= '0;
            heldByte <= '0;
            crcReg   <= '0;
        end else begin
            rxMeta   <= rx;
            rxs      <= rxMeta;
            rxsPrev  <= rxs;
            state    <= stateNxt;
            tick     <= tickNxt;
            bitCnt   <= bitCntNxt;
            shiftReg <= shiftNxt;
            parErr   <= parErrNxt;
            errReg   <= errNxt;
            if (fifo_we) begin
                heldByte <= byteVal;
                crcReg   <= crcNxt;
            end
        end
    end

    // The FIFO latches data_out with fifo_we, so the new byte is presented in that same cycle.
    assign data_out = fifo_we ? byteVal : heldByte;
    assign CRC      = crcReg;
    assign error    = errReg;

endmodule
